// File: rtl/ext_pipe_unit.sv
// ext_pipe_unit: registered multi-mode immediate extender for the MIPS-31 datapath.
// Covers the 5/16/18-bit extenders, LUI placement and the jump-target catenation.
// The result leaves through a main/skid register pair, so the unit sustains one
// result per cycle even when the consumer applies backpressure.
// Optional feature macro: EXT_PIPE_ILLEGAL_EN adds an out_err flag for modes 6/7.
module ext_pipe_unit #(
    parameter int OUT_WIDTH = 32,
    parameter int IN_WIDTH  = 26,
    parameter int TAG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_mode,
    input  logic [IN_WIDTH-1:0]  in_field,
    input  logic [OUT_WIDTH-1:0] in_pc,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
`ifdef EXT_PIPE_ILLEGAL_EN
    output logic                 out_err,
`endif
    output logic [TAG_WIDTH-1:0] out_tag
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                 state_reg;
    logic                   out_valid_reg;
    logic                   in_ready_reg;
    logic [OUT_WIDTH-1:0]   main_data_reg;
    logic [TAG_WIDTH-1:0]   main_tag_reg;
    logic [OUT_WIDTH-1:0]   skid_data_reg;
    logic [TAG_WIDTH-1:0]   skid_tag_reg;
`ifdef EXT_PIPE_ILLEGAL_EN
    logic                   main_err_reg;
    logic                   skid_err_reg;
`endif

    logic [OUT_WIDTH-1:0]   ext_data;
    logic                   ext_illegal;
    logic                   accept;
    logic                   unused_sink;

    // Low PC bits are replaced by the jump target and never consumed.
    assign unused_sink = ^{in_pc[27:0], in_field, ext_illegal};

    // in_ready is the registered copy, so acceptance never depends on out_ready combinationally.
    assign accept = in_valid && in_ready_reg;

    // Extension of the incoming field; start from zero and overlay the active bits so
    // that OUT_WIDTH=32 never needs a zero-width replication.
    always_comb begin
        ext_data    = '0;
        ext_illegal = 1'b0;
        case (in_mode)
            3'd0: ext_data[15:0] = in_field[15:0];
            3'd1: begin
                ext_data       = {OUT_WIDTH{in_field[15]}};
                ext_data[15:0] = in_field[15:0];
            end
            3'd2: ext_data[4:0] = in_field[4:0];
            3'd3: begin
                ext_data       = {OUT_WIDTH{in_field[15]}};
                ext_data[17:0] = {in_field[15:0], 2'b00};
            end
            3'd4: ext_data[31:16] = in_field[15:0];
            3'd5: begin
                ext_data[OUT_WIDTH-1:28] = in_pc[OUT_WIDTH-1:28];
                ext_data[27:0]           = {in_field[25:0], 2'b00};
            end
            default: ext_illegal = 1'b1;
        endcase
    end

    // Main/skid occupancy FSM; flush empties both entries and wins over every handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= EMPTY;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            main_data_reg <= '0;
            main_tag_reg  <= '0;
            skid_data_reg <= '0;
            skid_tag_reg  <= '0;
`ifdef EXT_PIPE_ILLEGAL_EN
            main_err_reg  <= 1'b0;
            skid_err_reg  <= 1'b0;
`endif
        end else if (flush) begin
            state_reg     <= EMPTY;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        main_data_reg <= ext_data;
                        main_tag_reg  <= in_tag;
`ifdef EXT_PIPE_ILLEGAL_EN
                        main_err_reg  <= ext_illegal;
`endif
                        state_reg     <= ONE;
                        out_valid_reg <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && out_ready) begin
                        main_data_reg <= ext_data;
                        main_tag_reg  <= in_tag;
`ifdef EXT_PIPE_ILLEGAL_EN
                        main_err_reg  <= ext_illegal;
`endif
                    end else if (accept) begin
                        skid_data_reg <= ext_data;
                        skid_tag_reg  <= in_tag;
`ifdef EXT_PIPE_ILLEGAL_EN
                        skid_err_reg  <= ext_illegal;
`endif
                        state_reg     <= TWO;
                        in_ready_reg  <= 1'b0;
                    end else if (out_ready) begin
                        state_reg     <= EMPTY;
                        out_valid_reg <= 1'b0;
                    end
                end
                TWO: begin
                    if (out_ready) begin
                        main_data_reg <= skid_data_reg;
                        main_tag_reg  <= skid_tag_reg;
`ifdef EXT_PIPE_ILLEGAL_EN
                        main_err_reg  <= skid_err_reg;
`endif
                        state_reg     <= ONE;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= EMPTY;
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = main_data_reg;
    assign out_tag   = main_tag_reg;
`ifdef EXT_PIPE_ILLEGAL_EN
    assign out_err   = main_err_reg;
`endif

endmodule

// File: tb/tb_ext_pipe_unit.sv
// tb_ext_pipe_unit: scoreboard bench for ext_pipe_unit (default 32-bit configuration).
// Expected results are queued when a request is accepted and compared when the
// DUT hands a result to the consumer.
module tb_ext_pipe_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_mode = '0;
    logic [25:0] in_field = '0;
    logic [31:0] in_pc = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
`ifdef EXT_PIPE_ILLEGAL_EN
    logic        out_err;
`endif

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    exp_t q[$];
    exp_t cur_exp;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic last_acc = 1'b0;
    logic rand_ready = 1'b0;

    ext_pipe_unit #(.OUT_WIDTH(32), .IN_WIDTH(26), .TAG_WIDTH(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_field  (in_field),
        .in_pc     (in_pc),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef EXT_PIPE_ILLEGAL_EN
        .out_err   (out_err),
`endif
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] m, input logic [25:0] f, input logic [31:0] pc);
        case (m)
            3'd0: return {16'h0000, f[15:0]};
            3'd1: return {{16{f[15]}}, f[15:0]};
            3'd2: return {27'h0, f[4:0]};
            3'd3: return {{14{f[15]}}, f[15:0], 2'b00};
            3'd4: return {f[15:0], 16'h0000};
            3'd5: return {pc[31:28], f, 2'b00};
            default: return 32'h0;
        endcase
    endfunction

    // One clock: observe the handshakes set up since the last edge, then advance.
    task automatic cycle();
        exp_t e;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        last_acc = 1'b0;
        if (flush) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_out", {63'd0, out_valid}, 64'd0);
                end else begin
                    e = q.pop_front();
                    check("out_data", {32'd0, out_data}, {32'd0, e.data});
                    check("out_tag", {59'd0, out_tag}, {59'd0, e.tag});
`ifdef EXT_PIPE_ILLEGAL_EN
                    check("out_err", {63'd0, out_err}, {63'd0, e.err});
`endif
                    $display("cycle %0d: result tag=%0d data=0x%08h", cyc, out_tag, out_data);
                end
            end else if (out_valid && q.size() > 0) begin
                check("hold_data", {32'd0, out_data}, {32'd0, q[0].data});
                check("hold_tag", {59'd0, out_tag}, {59'd0, q[0].tag});
            end
            if (in_valid && in_ready) begin
                q.push_back(cur_exp);
                last_acc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [2:0] m, input logic [25:0] f, input logic [31:0] pc,
                        input logic [4:0] t, input logic [31:0] d, input logic e);
        int n;
        in_mode  = m;
        in_field = f;
        in_pc    = pc;
        in_tag   = t;
        in_valid = 1'b1;
        cur_exp.data = d;
        cur_exp.tag  = t;
        cur_exp.err  = e;
        n = 0;
        last_acc = 1'b0;
        while (!last_acc && n < 50) begin
            cycle();
            n++;
        end
        check("send_accepted", {63'd0, last_acc}, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain_all();
        int n;
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        in_valid   = 1'b0;
        n = 0;
        while (q.size() > 0 && n < 50) begin
            cycle();
            n++;
        end
        check("drain_empty", 64'(q.size()), 64'd0);
        check("idle_out_valid", {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        int c0;
        logic [2:0]  m;
        logic [25:0] f;
        logic [31:0] pc;

        // Reset and idle
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_data", {32'd0, out_data}, 64'd0);
        check("rst_out_tag", {59'd0, out_tag}, 64'd0);

        // Directed modes with the consumer always ready
        out_ready = 1'b1;
        send(3'd1, 26'h0008001, 32'h0, 5'd1, 32'hFFFF8001, 1'b0);
        check("latency_valid", {63'd0, out_valid}, 64'd1);
        send(3'd0, 26'h0008001, 32'h0, 5'd2, 32'h00008001, 1'b0);
        send(3'd3, 26'h000FFFF, 32'h0, 5'd3, 32'hFFFFFFFC, 1'b0);
        send(3'd4, 26'h0001234, 32'h0, 5'd4, 32'h12340000, 1'b0);
        send(3'd2, 26'h3FFFFFF, 32'h0, 5'd5, 32'h0000001F, 1'b0);
        send(3'd5, 26'h0000010, 32'hA0000040, 5'h1F, 32'hA0000040, 1'b0);
        send(3'd6, 26'h3FFFFFF, 32'hFFFFFFFF, 5'd6, 32'h0, 1'b1);
        send(3'd7, 26'h0008001, 32'h0, 5'd7, 32'h0, 1'b1);
        drain_all();

        // Backpressure: tags 1..4 with the consumer stalled
        out_ready = 1'b0;
        send(3'd0, 26'h0000011, 32'h0, 5'd1, 32'h00000011, 1'b0);
        check("ready_after_one", {63'd0, in_ready}, 64'd1);
        send(3'd0, 26'h0000022, 32'h0, 5'd2, 32'h00000022, 1'b0);
        check("ready_after_two", {63'd0, in_ready}, 64'd0);
        cycle();
        check("stall_ready", {63'd0, in_ready}, 64'd0);
        check("stall_valid", {63'd0, out_valid}, 64'd1);
        out_ready = 1'b1;
        c0 = cyc;
        send(3'd0, 26'h0000033, 32'h0, 5'd3, 32'h00000033, 1'b0);
        send(3'd0, 26'h0000044, 32'h0, 5'd4, 32'h00000044, 1'b0);
        drain_all();
        check("release_cycles", 64'(cyc - c0), 64'd4);

        // Flush while both entries are full, with a request in the flush cycle
        out_ready = 1'b0;
        send(3'd1, 26'h0000055, 32'h0, 5'd8, 32'h00000055, 1'b0);
        send(3'd1, 26'h0000066, 32'h0, 5'd9, 32'h00000066, 1'b0);
        check("pre_flush_ready", {63'd0, in_ready}, 64'd0);
        flush = 1'b1;
        in_valid = 1'b1;
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", {63'd0, out_valid}, 64'd0);
        check("flush_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        cycle();
        check("post_flush_valid", {63'd0, out_valid}, 64'd0);

        // Asynchronous reset in the middle of a cycle
        out_ready = 1'b0;
        send(3'd4, 26'h000ABCD, 32'h0, 5'd10, 32'hABCD0000, 1'b0);
        send(3'd4, 26'h0001111, 32'h0, 5'd11, 32'h11110000, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", {63'd0, out_valid}, 64'd0);
        check("arst_ready", {63'd0, in_ready}, 64'd1);
        check("arst_data", {32'd0, out_data}, 64'd0);
        check("arst_tag", {59'd0, out_tag}, 64'd0);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Random stream with random consumer backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            m  = 3'($urandom_range(0, 7));
            f  = 26'($urandom);
            pc = $urandom;
            send(m, f, pc, 5'(i), model(m, f, pc), (m > 3'd5));
        end
        drain_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ext_pipe_unit.md
Name: ext_pipe_unit

Overview:
- Registered, multi-mode immediate extension unit for the MIPS-31 datapath.
- Replaces the separate 5/16/18-bit extenders and the PC/target catenation with one block.
- Accepts an instruction field slice, a mode, the current PC and a sideband tag over a valid/ready handshake. Returns the OUT_WIDTH operand one cycle later through a 2-entry skid buffer, giving full throughput under backpressure.
- Sits between decode and the ALU/PC-select operand muxes.

Parameters:
- OUT_WIDTH, 32, result width; legal range 32..64.
- IN_WIDTH, 26, instruction field width; minimum 26.
- TAG_WIDTH, 5, sideband tag carried alongside each result (e.g. destination register).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous drop of all buffered entries.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request this cycle.
- in_mode  input  3  extension mode; encodings listed under Behaviour.
- in_field  input  IN_WIDTH  instruction bits [IN_WIDTH-1:0].
- in_pc  input  OUT_WIDTH  PC used by JCAT.
- in_tag  input  TAG_WIDTH  sideband value, passed through unchanged.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  OUT_WIDTH  extended result.
- out_tag  output  TAG_WIDTH  tag matching out_data.

Behaviour:
- The clock port is clk. Reset rst is asynchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_tag=0, in_ready=1, skid buffer empty.
- Mode encodings (a = in_field):
  - 0 ZEXT16: zero-extend a[15:0].
  - 1 SEXT16: replicate a[15] into the upper bits.
  - 2 ZEXT5: zero-extend a[4:0] (shamt).
  - 3 BR18: sign-extend {a[15:0],2'b00}.
  - 4 LUI: {a[15:0],16'b0}, zero-extended to OUT_WIDTH.
  - 5 JCAT: {in_pc[OUT_WIDTH-1:28], a[25:0], 2'b00}.
  - 6, 7: illegal; result is 0.
- Extension is computed combinationally at input acceptance, then registered. Latency is 1 cycle from the in_valid&&in_ready edge to out_valid.
- Handshake:
  - A transfer occurs on an edge where valid&&ready.
  - out_data and out_tag are held stable while out_valid=1 and out_ready=0.
- Buffer structure:
  - Output register "main" plus one "skid" register.
  - in_ready is registered: in_ready = !skid_full.
- States (per main/skid occupancy):
  - EMPTY: main empty. An accept loads main and moves to ONE.
  - ONE: main full, skid empty.
    - Accept with out_ready=1: main is replaced, stay in ONE.
    - Accept with out_ready=0: load skid, move to TWO; in_ready drops on the next cycle.
    - No accept with out_ready=1: move to EMPTY.
  - TWO: main and skid full, in_ready=0.
    - out_ready=1: skid moves to main, move to ONE, in_ready=1 next cycle.
- Simultaneous accept and drain in ONE: no bubble, throughput 1/cycle.
- Order is strictly FIFO. No entry is lost or duplicated.
- flush: the next edge empties both entries, giving out_valid=0 and in_ready=1.
  - A request presented in the flush cycle is discarded.
  - flush takes priority over all handshakes.
- rst asserted mid-transfer: outputs return to reset values immediately, without waiting for a clock edge. In-flight data is discarded.

Optional Feature:
- Macro EXT_PIPE_ILLEGAL_EN.
- When defined:
  - Adds output port out_err (1 bit); its reset value is 0.
  - out_err is registered with the entry, travels through the skid buffer, and is asserted with the entry for modes 6/7.
  - out_data is still 0 for those modes.
- When undefined: no out_err port; modes 6/7 silently produce 0.

Test Plan:
- Reset then idle → out_valid=0, in_ready=1, out_data=0.
- SEXT16, field 0x0000_8001, out_ready=1 → next cycle out_data=0xFFFF8001. ZEXT16 with the same field → 0x00008001.
- BR18, field 0xFFFF; LUI, field 0x1234; ZEXT5, field 0x3FF_FFFF → 0xFFFFFFFC, 0x12340000, 0x0000001F respectively.
- JCAT, pc=0xA000_0040, field 0x0000010 → 0xA0000040. Tag 0x1F is returned alongside.
- Stream tags 1,2,3,4 with out_ready=0 from cycle 1:
  - in_ready falls after two accepts.
  - Releasing out_ready returns tags 1,2,3,4 in order, with no loss.
  - Full throughput of 1 result/cycle once out_ready=1.
- flush while in TWO → next cycle out_valid=0, in_ready=1. With EXT_PIPE_ILLEGAL_EN, mode 7 → out_data=0, out_err=1.
